activation_tap_buffer: RTL
==========================

Name: activation_tap_buffer

Overview:
- Producer-side history buffer for a 4-tap dilated causal conv1d layer.
- Accepts one packed activation vector per handshake, for example the previous layer's packed_out.
- Stores the vectors in a ring buffer and presents the four time-delayed vectors the conv layer reads as packed_a0..packed_a3.
- Sits between consecutive conv layers: it writes history as one layer produces output, and the next layer reads it back as taps.

Parameters:
- W, 16: bit width of each element (signed fixed point).
- D, 16: number of elements per packed vector.
- DILATION, 1: spacing between taps, in samples.
- ADDR_W, 3: ring address width; depth is 2**ADDR_W. Elaboration must error unless 2**ADDR_W >= 3*DILATION+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset: the block resets on a clk edge where rst==0.
- inp_v  in  1  packed_inp valid.
- packed_inp  in  D*W  incoming vector; element j is at [(D-j)*W-1:(D-j-1)*W].
- inp_ready  out  1  block can accept a vector this cycle.
- packed_a0  out  D*W  x[t-3*DILATION] (oldest tap).
- packed_a1  out  D*W  x[t-2*DILATION].
- packed_a2  out  D*W  x[t-DILATION].
- packed_a3  out  D*W  x[t] (newest tap).
- out_v  out  1  taps valid and stable.
- out_ack  in  1  consumer has finished with the taps.

Behaviour:
- Reset (rst==0 at an edge):
  - state <= CLEAR, clr_addr <= 0, wr_ptr <= 0.
  - out_v <= 0, inp_ready <= 0, all packed_a* <= 0.
  - Any in-flight transaction is discarded. Reset has priority over every other event.
- CLEAR:
  - Writes zero to mem[clr_addr] and increments clr_addr, one entry per cycle, for 2**ADDR_W cycles.
  - After the last entry, state <= IDLE.
  - inp_ready=0 throughout. History therefore starts zero-padded, which gives causal padding.
- IDLE:
  - inp_ready=1, registered, high only in IDLE.
  - On an edge with inp_v&&inp_ready (accept edge T): mem[wr_ptr] <= packed_inp, tap index k <= 3, state <= READ.
  - inp_ready drops after edge T.
- READ, four cycles, edges T+1..T+4:
  - Each cycle reads mem[(wr_ptr - (3-k')*DILATION) mod 2**ADDR_W] into one tap register, in the order a3, a2, a1, a0. Here k' is the tap being loaded.
  - Address arithmetic is ADDR_W-bit unsigned with natural wrap.
  - The read at T+1 must return the vector written at T (write-then-read in consecutive cycles).
  - After edge T+4, state <= HOLD and out_v <= 1.
  - Latency from the accept edge to out_v high is exactly 4 edges. out_v is observed high in the cycle after edge T+4.
- HOLD:
  - out_v=1; packed_a* held constant; inp_ready=0.
  - On an edge with out_ack=1: out_v <= 0, wr_ptr <= wr_ptr+1 (wraps), state <= IDLE.
  - out_ack in any other state is ignored.
  - inp_v outside IDLE is not accepted, and packed_inp is not sampled.
- Taps are copies of stored data only: no arithmetic, no saturation.
- Before 3*DILATION+1 samples have been accepted, older taps read 0.
- After the ring wraps, the oldest entries are overwritten. This is legal because depth >= 3*DILATION+1.
- States: CLEAR, IDLE, READ, HOLD.

Decomposition:
- Package activation_tap_pkg holds:
  - NUM_TAPS=4.
  - the state enum {CLEAR, IDLE, READ, HOLD}.
  - a function computing tap address from (wr_ptr, tap, DILATION, ADDR_W).
- Sub-module activation_ring_ram:
  - 2**ADDR_W x (D*W) storage, one write port, one registered read port.
  - Parameters D, W, ADDR_W.
  - Inferable as BRAM.
- The top level contains the FSM, pointers and tap registers.

Test Plan:
- Reset release, ADDR_W=3: inp_ready stays 0 for exactly 8 cycles and then goes to 1; out_v=0 and all packed_a*=0 throughout.
- Single sample, DILATION=1: accept x0 with all lanes 16'h0100. out_v rises exactly 4 edges after the accept edge, with packed_a3 lanes = 16'h0100 and a2=a1=a0=0. Assert out_ack for one cycle: out_v falls on the next edge and inp_ready is 1 one cycle later.
- Fill and wrap, DILATION=1, ADDR_W=3: stream x0..x9, each lane j of x_s = s*256+j, acking each output.
  - After x3: a0=x0, a1=x1, a2=x2, a3=x3.
  - After x9: a0=x6, a1=x7, a2=x8, a3=x9.
- Dilation, DILATION=2, ADDR_W=3: stream x0..x6 with the same pattern. After x6: a3=x6, a2=x4, a1=x2, a0=x0. After x2: a3=x2, a2=x0, a1=0, a0=0.
- Backpressure: in HOLD, keep out_ack=0 for 20 cycles while toggling inp_v and randomising packed_inp. The taps remain bit-identical, inp_ready stays 0, and no write occurs (the next accepted sample lands at wr_ptr+1).
- Reset mid-operation: pull rst low at edge T+2 of a READ. On that edge out_v=0 and inp_ready=0, and CLEAR reruns. The next sample xN yields a3=xN and a2=a1=a0=0, so prior history is zeroed.

Source files
------------

// File: rtl/activation_tap_pkg.sv
// Shared types and helpers for the conv1d activation tap buffer.
package activation_tap_pkg;

    localparam int NUM_TAPS = 4;

    typedef enum logic [1:0] {CLEAR, IDLE, READ, HOLD} state_e;

    // Ring address of tap `tap` (NUM_TAPS-1 is newest) relative to the write pointer, wrapped to addr_w bits.
    function automatic int unsigned tap_addr(int unsigned wr_ptr, int unsigned tap,
                                             int unsigned dilation, int unsigned addr_w);
        int unsigned offs;
        offs = (NUM_TAPS - 1 - tap) * dilation;
        return (wr_ptr - offs) & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/activation_ring_ram.sv
// Ring storage for packed activation vectors: one write port, one registered
// write-first read port so a same-edge write/read of one address returns new data.
module activation_ring_ram #(
    parameter int D      = 16,
    parameter int W      = 16,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [D*W-1:0]      wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [D*W-1:0]      rdata_o
);

    logic [D*W-1:0] mem_q [2**ADDR_W];
    logic [D*W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/activation_tap_buffer.sv
// History ring for a 4-tap dilated causal conv1d: stores one packed vector per
// handshake and presents the four time-delayed taps until the consumer acks.
import activation_tap_pkg::*;

module activation_tap_buffer #(
    parameter int W        = 16,
    parameter int D        = 16,
    parameter int DILATION = 1,
    parameter int ADDR_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inp_v,
    input  logic [D*W-1:0]  packed_inp,
    output logic            inp_ready,
    output logic [D*W-1:0]  packed_a0,
    output logic [D*W-1:0]  packed_a1,
    output logic [D*W-1:0]  packed_a2,
    output logic [D*W-1:0]  packed_a3,
    output logic            out_v,
    input  logic            out_ack
);

    localparam int DEPTH = 2**ADDR_W;

    if (DEPTH < 3*DILATION + 1) begin : g_depth_check
        $error("activation_tap_buffer: ring depth %0d too small for DILATION %0d", DEPTH, DILATION);
    end

    state_e             state_q;
    logic [ADDR_W-1:0]  clr_addr_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [1:0]         tap_q;
    logic               inp_ready_q;
    logic               out_v_q;
    logic [D*W-1:0]     taps_q [NUM_TAPS];

    logic               accept;
    logic [1:0]         rd_tap_d;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  raddr;
    logic [D*W-1:0]     wdata;
    logic [D*W-1:0]     rdata;

    assign accept = (state_q == IDLE) && inp_v && inp_ready_q;

    // The read port runs one tap ahead of the tap register being loaded: the newest
    // tap is read on the accept edge itself (write-first), then a2, a1, a0 follow.
    always_comb begin
        rd_tap_d = 2'(NUM_TAPS - 1);
        if ((state_q == READ) && (tap_q != 2'd0)) begin
            rd_tap_d = tap_q - 2'd1;
        end
    end

    assign raddr = ADDR_W'(tap_addr(32'(wr_ptr_q), 32'(rd_tap_d), DILATION, ADDR_W));
    assign we    = (state_q == CLEAR) || accept;
    assign waddr = (state_q == CLEAR) ? clr_addr_q : wr_ptr_q;
    assign wdata = (state_q == CLEAR) ? '0 : packed_inp;

    activation_ring_ram #(
        .D      (D),
        .W      (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            wr_ptr_q    <= '0;
            tap_q       <= 2'(NUM_TAPS - 1);
            inp_ready_q <= 1'b0;
            out_v_q     <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= IDLE;
                        inp_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        tap_q       <= 2'(NUM_TAPS - 1);
                        inp_ready_q <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    taps_q[tap_q] <= rdata;
                    if (tap_q == 2'd0) begin
                        out_v_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        tap_q <= tap_q - 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        out_v_q     <= 1'b0;
                        wr_ptr_q    <= wr_ptr_q + 1'b1;
                        inp_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign inp_ready = inp_ready_q;
    assign out_v     = out_v_q;
    assign packed_a0 = taps_q[0];
    assign packed_a1 = taps_q[1];
    assign packed_a2 = taps_q[2];
    assign packed_a3 = taps_q[3];

endmodule
